// File: rtl/tlc_sink.sv
// Receiving end of the LED-driver serial bus: per-lane grayscale/dot-correction
// shift registers and latches, a shared grayscale counter and per-channel PWM outputs.
module tlc_sink #(
   parameter int LANES    = 12,
   parameter int CHANNELS = 16,
   parameter int GS_BITS  = 12,
   parameter int DC_BITS  = 6
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          led_sclk,
   input  logic [LANES-1:0]              led_sin,
   input  logic                          led_mode,
   input  logic                          led_xlat,
   input  logic                          led_blank,
   input  logic                          led_gsclk,
   input  logic [$clog2(LANES)-1:0]      rd_lane,
   input  logic [$clog2(CHANNELS)-1:0]   rd_chan,
   output logic [GS_BITS-1:0]            rd_gs,
   output logic [DC_BITS-1:0]            rd_dc,
   output logic [LANES*CHANNELS-1:0]     pwm,
   output logic [15:0]                   frame_count,
   output logic [8:0]                    bit_count,
   output logic                          len_err
);

   localparam int LANE_W   = $clog2(LANES);
   localparam int CHAN_W   = $clog2(CHANNELS);
   localparam int FRAME    = CHANNELS * GS_BITS;
   localparam int DC_FRAME = CHANNELS * DC_BITS;
   localparam logic [GS_BITS:0] GS_MAX   = {1'b1, {GS_BITS{1'b0}}};
   localparam logic [8:0]       BIT_SAT  = 9'h1FF;

   logic                    sclk_q, xlat_q, gsclk_q;
   logic                    sclk_rise, xlat_rise, gsclk_rise;
   logic [FRAME-1:0]        shift_q  [LANES];
   logic [FRAME-1:0]        gs_latch [LANES];
   logic [DC_FRAME-1:0]     dc_latch [LANES];
   logic [GS_BITS:0]        gs_cnt;
   logic [LANES*CHANNELS-1:0] pwm_q, pwm_next;
   logic [8:0]              expected_len;

   assign sclk_rise  = led_sclk  & ~sclk_q;
   assign xlat_rise  = led_xlat  & ~xlat_q;
   assign gsclk_rise = led_gsclk & ~gsclk_q;
   assign expected_len = led_mode ? 9'(DC_FRAME) : 9'(FRAME);

   always_ff @(posedge clock) begin
      if (reset) begin
         sclk_q      <= 1'b0;
         xlat_q      <= 1'b0;
         gsclk_q     <= 1'b0;
         frame_count <= '0;
         bit_count   <= '0;
         len_err     <= 1'b0;
         gs_cnt      <= '0;
         pwm_q       <= '0;
         for (int l = 0; l < LANES; l++) begin
            shift_q[l]  <= '0;
            gs_latch[l] <= '0;
            dc_latch[l] <= '0;
         end
      end else begin
         sclk_q  <= led_sclk;
         xlat_q  <= led_xlat;
         gsclk_q <= led_gsclk;

         // Latch reads the pre-shift register, so a coincident sclk edge lands in the next frame.
         if (sclk_rise) begin
            for (int l = 0; l < LANES; l++)
               shift_q[l] <= {shift_q[l][FRAME-2:0], led_sin[l]};
         end

         if (xlat_rise) begin
            for (int l = 0; l < LANES; l++) begin
               if (led_mode) dc_latch[l] <= shift_q[l][DC_FRAME-1:0];
               else          gs_latch[l] <= shift_q[l];
            end
            frame_count <= frame_count + 16'd1;
            bit_count   <= sclk_rise ? 9'd1 : 9'd0;
            if (bit_count != expected_len) len_err <= 1'b1;
         end else if (sclk_rise && bit_count != BIT_SAT) begin
            bit_count <= bit_count + 9'd1;
         end

         if (led_blank)
            gs_cnt <= '0;
         else if (gsclk_rise && gs_cnt != GS_MAX)
            gs_cnt <= gs_cnt + 1'b1;

         pwm_q <= pwm_next;
      end
   end

   always_comb begin
      pwm_next = '0;
      for (int l = 0; l < LANES; l++)
         for (int c = 0; c < CHANNELS; c++)
            pwm_next[l*CHANNELS+c] = !led_blank &&
               (gs_cnt < {1'b0, gs_latch[l][c*GS_BITS +: GS_BITS]});
   end

   assign pwm = pwm_q;

   always_comb begin
      rd_gs = '0;
      rd_dc = '0;
      for (int l = 0; l < LANES; l++)
         for (int c = 0; c < CHANNELS; c++)
            if (rd_lane == LANE_W'(l) && rd_chan == CHAN_W'(c)) begin
               rd_gs = gs_latch[l][c*GS_BITS +: GS_BITS];
               rd_dc = dc_latch[l][c*DC_BITS +: DC_BITS];
            end
   end

endmodule

// File: tb/tb_tlc_sink.sv
// Bench for tlc_sink: random frames and grayscale sequences checked against a
// transaction-level model (bit history per lane, per-channel values, PWM counter).
module tb_tlc_sink;

   localparam int LANES    = 12;
   localparam int CHANNELS = 16;
   localparam int GS_BITS  = 12;
   localparam int DC_BITS  = 6;
   localparam int FRAME    = CHANNELS * GS_BITS;
   localparam int DC_FRAME = CHANNELS * DC_BITS;
   localparam int GS_MAX   = 1 << GS_BITS;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic                 led_sclk = 1'b0, led_mode = 1'b0, led_xlat = 1'b0;
   logic                 led_blank = 1'b1, led_gsclk = 1'b0;
   logic [LANES-1:0]     led_sin = '0;
   logic [3:0]           rd_lane = '0, rd_chan = '0;
   logic [GS_BITS-1:0]   rd_gs;
   logic [DC_BITS-1:0]   rd_dc;
   logic [LANES*CHANNELS-1:0] pwm;
   logic [15:0]          frame_count;
   logic [8:0]           bit_count;
   logic                 len_err;

   tlc_sink dut (
      .clock(clock), .reset(reset), .led_sclk(led_sclk), .led_sin(led_sin),
      .led_mode(led_mode), .led_xlat(led_xlat), .led_blank(led_blank),
      .led_gsclk(led_gsclk), .rd_lane(rd_lane), .rd_chan(rd_chan),
      .rd_gs(rd_gs), .rd_dc(rd_dc), .pwm(pwm), .frame_count(frame_count),
      .bit_count(bit_count), .len_err(len_err)
   );

   // scoreboard / model state
   int checks = 0;
   int failures = 0;
   logic [LANES-1:0] exp_q[$];   // sin vectors shifted since reset, newest last
   int exp_gs [LANES][CHANNELS];
   int exp_dc [LANES][CHANNELS];
   int frame_v [LANES][CHANNELS];
   int exp_frames, exp_bits, exp_cnt;
   bit exp_len_err, exp_blank;

   task automatic check(string tag, logic [191:0] got, logic [191:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int model_field(int lane, int chan, int nbits);
      int v = 0;
      for (int b = 0; b < nbits; b++) begin
         int idx = exp_q.size() - 1 - (chan * nbits + b);
         if (idx >= 0 && exp_q[idx][lane]) v |= (1 << b);
      end
      return v;
   endfunction

   function automatic logic [191:0] model_pwm();
      logic [191:0] r = '0;
      for (int l = 0; l < LANES; l++)
         for (int c = 0; c < CHANNELS; c++)
            r[l*CHANNELS+c] = !exp_blank && (exp_cnt < exp_gs[l][c]);
      return r;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      for (int l = 0; l < LANES; l++)
         for (int c = 0; c < CHANNELS; c++) begin
            exp_gs[l][c] = 0;
            exp_dc[l][c] = 0;
         end
      exp_frames = 0; exp_bits = 0; exp_cnt = 0; exp_len_err = 0;
   endtask

   task automatic model_shift(logic [LANES-1:0] v);
      exp_q.push_back(v);
      if (exp_q.size() > FRAME) void'(exp_q.pop_front());
      if (exp_bits < 511) exp_bits++;
   endtask

   task automatic model_latch(bit mode);
      if (exp_bits != (mode ? DC_FRAME : FRAME)) exp_len_err = 1;
      for (int l = 0; l < LANES; l++)
         for (int c = 0; c < CHANNELS; c++)
            if (mode) exp_dc[l][c] = model_field(l, c, DC_BITS);
            else      exp_gs[l][c] = model_field(l, c, GS_BITS);
      exp_frames = (exp_frames + 1) % 65536;
      exp_bits = 0;
   endtask

   // driver tasks
   task automatic do_reset();
      reset = 1'b1; led_sclk = 0; led_xlat = 0; led_gsclk = 0; led_blank = 1;
      exp_blank = 1;
      tick(); tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic send_bit(logic [LANES-1:0] v);
      led_sin = v; led_sclk = 1'b1; tick();
      led_sclk = 1'b0; tick();
      model_shift(v);
   endtask

   task automatic send_random_bits(int n);
      for (int i = 0; i < n; i++) send_bit(LANES'($urandom));
   endtask

   task automatic send_frame(int nb);
      for (int c = CHANNELS - 1; c >= 0; c--)
         for (int b = nb - 1; b >= 0; b--) begin
            logic [LANES-1:0] v;
            for (int l = 0; l < LANES; l++) v[l] = frame_v[l][c][b];
            send_bit(v);
         end
   endtask

   task automatic randomize_frame(int nb);
      for (int l = 0; l < LANES; l++)
         for (int c = 0; c < CHANNELS; c++)
            frame_v[l][c] = $urandom_range(0, (1 << nb) - 1);
   endtask

   task automatic latch(bit mode);
      led_mode = mode; led_xlat = 1'b1; tick();
      led_xlat = 1'b0; tick();
      model_latch(mode);
   endtask

   task automatic gs_pulse();
      led_gsclk = 1'b1; tick();
      led_gsclk = 1'b0; tick();
      if (!exp_blank && exp_cnt < GS_MAX) exp_cnt++;
   endtask

   task automatic set_blank(bit v);
      led_blank = v; tick(); tick();
      exp_blank = v;
      if (v) exp_cnt = 0;
   endtask

   task automatic check_readback(string tag);
      for (int l = 0; l < LANES; l++)
         for (int c = 0; c < CHANNELS; c++) begin
            rd_lane = 4'(l); rd_chan = 4'(c); #1;
            check({tag, "_gs"}, 192'(rd_gs), 192'(exp_gs[l][c]));
            check({tag, "_dc"}, 192'(rd_dc), 192'(exp_dc[l][c]));
         end
   endtask

   task automatic check_status(string tag);
      check({tag, "_frames"}, 192'(frame_count), 192'(exp_frames));
      check({tag, "_bits"},   192'(bit_count),   192'(exp_bits));
      check({tag, "_len_err"}, 192'(len_err),    192'(exp_len_err));
      check({tag, "_pwm"},    192'(pwm),         model_pwm());
   endtask

   initial begin
      do_reset();
      check("reset_pwm", 192'(pwm), 192'd0);
      check_status("reset");

      // 1: lane0 chan15 = 0xFFF, everything else 0
      for (int l = 0; l < LANES; l++)
         for (int c = 0; c < CHANNELS; c++) frame_v[l][c] = 0;
      frame_v[0][15] = 12'hFFF;
      send_frame(GS_BITS);
      latch(1'b0);
      rd_lane = 4'd0; rd_chan = 4'd15; #1;
      check("t1_gs_0_15", 192'(rd_gs), 192'hFFF);
      rd_chan = 4'd0; #1;
      check("t1_gs_0_0", 192'(rd_gs), 192'd0);
      check("t1_frames", 192'(frame_count), 192'd1);
      check("t1_bits", 192'(bit_count), 192'd0);
      check("t1_len_err", 192'(len_err), 192'd0);
      check_readback("t1");

      // 2: chan0 = 3 on all lanes, random elsewhere; count through blank release
      randomize_frame(GS_BITS);
      for (int l = 0; l < LANES; l++) frame_v[l][0] = 3;
      send_frame(GS_BITS);
      latch(1'b0);
      check_readback("t2");
      set_blank(1'b0);
      check("t2_pwm0_start", 192'(pwm[0]), 192'd1);
      check_status("t2_start");
      for (int k = 1; k <= 5; k++) begin
         gs_pulse();
         check("t2_pwm0", 192'(pwm[0]), 192'(k < 3));
         check("t2_pwm", 192'(pwm), model_pwm());
      end
      set_blank(1'b1);
      check("t2_blank_pwm", 192'(pwm), 192'd0);
      gs_pulse();
      check("t2_blank_gsclk_pwm", 192'(pwm), 192'd0);

      // 4: full frame, then sclk and xlat rising in the same cycle
      randomize_frame(GS_BITS);
      send_frame(GS_BITS);
      begin
         logic [LANES-1:0] v = LANES'($urandom);
         led_sin = v; led_mode = 1'b0; led_sclk = 1'b1; led_xlat = 1'b1; tick();
         led_sclk = 1'b0; led_xlat = 1'b0; tick();
         model_latch(1'b0);
         model_shift(v);
      end
      check("t4_bits", 192'(bit_count), 192'd1);
      check_status("t4");
      check_readback("t4");

      // 3: DC frame, short GS frame, then DC again
      send_random_bits(FRAME - 1 - DC_FRAME);  // completes nothing; restart below
      latch(1'b0);                             // wrong length -> len_err
      check("t3_len_err_set", 192'(len_err), 192'd1);
      do_reset();
      randomize_frame(DC_BITS);
      send_frame(DC_BITS);
      latch(1'b1);
      check("t3_dc_len_err", 192'(len_err), 192'd0);
      check_readback("t3_dc");
      send_random_bits(FRAME - 1);
      latch(1'b0);
      check("t3_short_len_err", 192'(len_err), 192'd1);
      check_status("t3_short");
      randomize_frame(DC_BITS);
      send_frame(DC_BITS);
      latch(1'b1);
      check("t3_sticky", 192'(len_err), 192'd1);
      check_readback("t3_dc2");

      send_random_bits(520);
      check("bits_saturate", 192'(bit_count), 192'd511);

      // 5: saturating grayscale counter with lane0 chan0 = 0xFFF
      randomize_frame(GS_BITS);
      frame_v[0][0] = 12'hFFF;
      send_frame(GS_BITS);
      latch(1'b0);
      set_blank(1'b0);
      for (int k = 0; k < GS_MAX - 2; k++) gs_pulse();
      check("t5_pwm_4094", 192'(pwm[0]), 192'd1);
      check("t5_pwm_all_4094", 192'(pwm), model_pwm());
      gs_pulse();
      check("t5_pwm_4095", 192'(pwm[0]), 192'd0);
      for (int k = GS_MAX - 1; k < 5000; k++) gs_pulse();
      check("t5_pwm_5000", 192'(pwm), model_pwm());
      led_blank = 1'b1; led_gsclk = 1'b1; tick();
      led_blank = 1'b0; led_gsclk = 1'b0; tick(); tick();
      exp_blank = 0; exp_cnt = 0;
      check("t5_blank_beats_gsclk", 192'(pwm[0]), 192'd1);
      check("t5_blank_pwm", 192'(pwm), model_pwm());

      // 6: reset mid-shift, then a clean frame
      send_random_bits(100);
      do_reset();
      check("t6_pwm", 192'(pwm), 192'd0);
      check_status("t6_reset");
      check_readback("t6_reset");
      randomize_frame(GS_BITS);
      send_frame(GS_BITS);
      latch(1'b0);
      check_status("t6_frame");
      check_readback("t6_frame");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
